// File: rtl/header_chunk_loader.sv
// Streams an 80-byte block header in as 32-bit words and assembles
// the 512-bit first chunk and 128-bit tail chunk for the SHA-256 core.
module header_chunk_loader #(
  parameter int WORD_W       = 32,
  parameter int HEADER_WORDS = 20,
  parameter int CHUNK1_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WORD_W-1:0]            word_in,
  input  logic                         word_valid,
  output logic                         word_ready,
  input  logic                         block_consume,
  input  logic                         flush,
  output logic [CHUNK1_WORDS*WORD_W-1:0] chunk1,
  output logic [(HEADER_WORDS-CHUNK1_WORDS)*WORD_W-1:0] chunk2,
  output logic                         block_ready,
  output logic [4:0]                   word_count
);

  localparam int CHUNK2_WORDS = HEADER_WORDS - CHUNK1_WORDS;
  localparam logic [4:0] LAST = 5'(HEADER_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] count_next;
  logic       accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      word_count <= 5'd0;
    end else begin
      state      <= state_next;
      word_count <= count_next;
    end
  end

  // flush outranks consume and acceptance; word_ready already folds it in
  always_comb begin
    state_next  = state;
    count_next  = word_count;
    word_ready  = (state == FILL) && !flush;
    block_ready = (state == FULL);
    accept      = word_valid && word_ready;
    if (flush) begin
      state_next = FILL;
      count_next = 5'd0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            count_next = word_count + 5'd1;
            if (word_count == LAST) state_next = FULL;
          end
        end
        FULL: begin
          if (block_consume) begin
            state_next = FILL;
            count_next = 5'd0;
          end
        end
        default: begin
          state_next = FILL;
          count_next = 5'd0;
        end
      endcase
    end
  end

  // Word k lands MSB-first: chunk1 holds words 0..15, chunk2 words 16..19
  always_ff @(posedge clk) begin
    if (rst) begin
      chunk1 <= '0;
      chunk2 <= '0;
    end else if (accept) begin
      for (int i = 0; i < CHUNK1_WORDS; i++) begin
        if (word_count == 5'(i))
          chunk1[(CHUNK1_WORDS-1-i)*WORD_W +: WORD_W] <= word_in;
      end
      for (int i = 0; i < CHUNK2_WORDS; i++) begin
        if (word_count == 5'(CHUNK1_WORDS + i))
          chunk2[(CHUNK2_WORDS-1-i)*WORD_W +: WORD_W] <= word_in;
      end
    end
  end

endmodule

// File: tb/tb_header_chunk_loader.sv
// Directed and random stimulus for header_chunk_loader, checked
// against a word-array model of the header being assembled.
module tb_header_chunk_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         block_consume = 1'b0;
  logic         flush = 1'b0;
  logic [511:0] chunk1;
  logic [127:0] chunk2;
  logic         block_ready;
  logic [4:0]   word_count;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_hdr [20];
  int          m_cnt  = 0;
  bit          m_full = 1'b0;

  header_chunk_loader dut (
    .clk(clk),
    .rst(rst),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .block_consume(block_consume),
    .flush(flush),
    .chunk1(chunk1),
    .chunk2(chunk2),
    .block_ready(block_ready),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_c1();
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) v[511-32*i -: 32] = m_hdr[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_c2();
    logic [127:0] v = '0;
    for (int i = 0; i < 4; i++) v[127-32*i -: 32] = m_hdr[16+i];
    return v;
  endfunction

  task automatic model(input logic r, v, input logic [31:0] w,
                       input logic c, f);
    if (r) begin
      m_cnt = 0;
      m_full = 1'b0;
      for (int i = 0; i < 20; i++) m_hdr[i] = '0;
    end else if (f) begin
      m_cnt = 0;
      m_full = 1'b0;
    end else if (m_full) begin
      if (c) begin
        m_full = 1'b0;
        m_cnt = 0;
      end
    end else if (v) begin
      m_hdr[m_cnt] = w;
      m_cnt++;
      if (m_cnt == 20) m_full = 1'b1;
    end
  endtask

  task automatic step(input logic r, v, input logic [31:0] w,
                      input logic c, f);
    @(negedge clk);
    rst = r;
    word_valid = v;
    word_in = w;
    block_consume = c;
    flush = f;
    #1;
    if (!r) check("word_ready", 512'(word_ready), 512'(!m_full && !f));
    @(posedge clk);
    model(r, v, w, c, f);
    #1;
    check("word_count", 512'(word_count), 512'(m_cnt));
    check("block_ready", 512'(block_ready), 512'(m_full));
    check("chunk1", chunk1, exp_c1());
    check("chunk2", 512'(chunk2), 512'(exp_c2()));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic stream(input logic [31:0] base, input bit gapped);
    int n = 0;
    while (n < 20) begin
      if (gapped && n[0] == 1'b0 && (n > 0 || base[0])) begin
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, base + 32'(n), 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h1234, 1'b1, 1'b1);
    idle();

    // 1: back-to-back stream
    stream(32'h1, 1'b0);
    check("s1_c1_top", 512'(chunk1[511:480]), 512'(32'h1));
    check("s1_c1_bot", 512'(chunk1[31:0]), 512'(32'h10));
    check("s1_c2", 512'(chunk2),
          512'(128'h00000011_00000012_00000013_00000014));
    check("s1_ready", 512'(block_ready), 512'(1'b1));

    // 3: backpressure in FULL then consume
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("s3_count", 512'(word_count), 512'(5'd0));
    step(1'b0, 1'b1, 32'hCAFE0000, 1'b0, 1'b0);
    check("s3_first", 512'(chunk1[511:480]), 512'(32'hCAFE0000));

    // 2: gapped valid, from a flushed start
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    stream(32'h1, 1'b1);
    check("s2_c2", 512'(chunk2),
          512'(128'h00000011_00000012_00000013_00000014));
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // 4: flush mid-fill while valid
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
    check("s4_count", 512'(word_count), 512'(5'd0));
    stream(32'h100, 1'b0);

    // 5: flush and consume together in FULL
    step(1'b0, 1'b1, 32'h5, 1'b1, 1'b1);
    check("s5_ready", 512'(block_ready), 512'(1'b0));
    idle();

    // 6: reset after 12 words
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h999, 1'b0, 1'b0);
    check("s6_c1", chunk1, 512'(0));
    idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom(),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/header_chunk_loader.md
Name: header_chunk_loader

Overview:
- Write-side counterpart of the chunk selector that feeds the SHA-256 core.
- Receives an 80-byte Bitcoin block header as a stream of 32-bit words over a valid/ready handshake.
- Assembles the stream into the 512-bit first chunk and the 128-bit tail chunk, then holds both stable with block_ready asserted until the hashing side consumes them.

Parameters:
- WORD_W, 32: input word width in bits; only 32 is supported, since the output widths depend on it.
- HEADER_WORDS, 20: words per header; fixed at 20, which is 640 bits.
- CHUNK1_WORDS, 16: words routed to chunk1; the remaining 4 go to chunk2.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- word_in  in  32  header word; the most significant header word arrives first.
- word_valid  in  1  word_in holds a valid word.
- word_ready  out  1  loader can accept a word this cycle.
- block_consume  in  1  single-cycle pulse from the hashing side; releases the current block.
- flush  in  1  abandons a partial or complete block.
- chunk1  out  512  header words 0..15.
- chunk2  out  128  header words 16..19.
- block_ready  out  1  chunk1 and chunk2 hold a complete header.
- word_count  out  5  number of words accepted for the current block, 0..20.

Behaviour:
- Reset:
  - When rst is high at a clock edge: state goes to FILL; word_count=0; block_ready=0; chunk1=0; chunk2=0.
  - word_ready=1 in the first cycle after reset is released.
  - rst overrides every other input, including a word in mid-transfer.
- States: FILL and FULL. word_ready=1 exactly when in FILL and flush=0; word_ready is combinational from state and flush.
- Accept condition: a word is accepted when word_valid && word_ready at the clock edge.
- Word placement:
  - Word k (k = word_count before acceptance) is written into the register slice for index k.
  - For k<16: chunk1[511-32k -: 32].
  - For 16<=k<20: chunk2[127-32(k-16) -: 32].
  - word_count increments by 1 on each accept.
- FILL to FULL:
  - Taken on the edge that accepts the word with k=19.
  - block_ready is 1 in the following cycle, a 1-cycle latency from the last accept.
  - word_count reads 20 while in FULL.
- FULL:
  - word_ready=0 and word_valid is ignored; chunk1 and chunk2 are frozen.
- FULL to FILL on block_consume=1:
  - word_count returns to 0 and block_ready returns to 0 on the next cycle.
  - chunk registers keep their old contents until they are overwritten word by word.
- block_consume while in FILL: ignored, with no effect.
- Flush:
  - flush=1 in any state: word_count goes to 0, block_ready goes to 0, and state goes to FILL on the next edge.
  - Chunk contents are untouched.
  - No word is accepted in a cycle where flush=1.
  - flush has priority over block_consume and over word acceptance.
- Simultaneous flush and block_consume in FULL: the result is the same as flush alone.
- word_count never exceeds 20 and never wraps.
- No combinational path from word_in to any output.
- chunk1 and chunk2 are fed directly into the existing chunk selector: hash_select=0 selects chunk1; otherwise chunk2 is used with the fixed padding appended.

Test Plan:
1. Reset then stream: stream words 0x00000001..0x00000014 with word_valid held high every cycle.
   - Required: chunk1[511:480]=0x00000001 and chunk1[31:0]=0x00000010.
   - Required: chunk2 = 0x00000011_00000012_00000013_00000014.
   - Required: block_ready rises the cycle after the 20th accept, and word_ready=0 from that cycle.
2. Gapped valid: present 20 words with word_valid toggling 1/0.
   - Required: word_count increments only on valid cycles, and the final chunks match scenario 1.
3. Backpressure: in FULL, hold word_valid=1 with word_in=0xDEADBEEF for 10 cycles.
   - Required: chunks unchanged, word_count=20.
   - Then pulse block_consume: the next cycle shows block_ready=0, word_count=0, word_ready=1.
   - The first new word lands in chunk1[511:480].
4. Flush mid-fill: after 7 words, assert flush for one cycle while word_valid=1.
   - Required: that word is not accepted and word_count=0 next cycle.
   - Then 20 new words produce a correct block.
5. Concurrent flush and block_consume: assert both in FULL.
   - Required: state goes to FILL and block_ready=0, with no double count and no error.
6. Reset mid-operation: assert rst after 12 words with word_valid=1.
   - Required: next cycle word_count=0, chunk1=0, chunk2=0, block_ready=0.
